// File: rtl/wide_add_sequencer.sv
// rtl/wide_add_sequencer.sv - multi-word adder sequencer around a 32-bit carry-skip adder
// Adds two W-bit operands one 32-bit word per clock, LSW first, carry registered between words.

module CarrySkipAdder32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);
    logic [31:0] w_p;
    assign w_p = i_a ^ i_b;

    // 4-bit ripple groups; a group whose bits all propagate forwards its carry-in directly
    always_comb begin : csa
        logic [32:0] c;
        logic        rc;
        c     = '0;
        rc    = 1'b0;
        c[0]  = i_cin;
        for (int blk = 0; blk < 8; blk++) begin
            rc = c[4*blk];
            for (int bit_i = 0; bit_i < 4; bit_i++) begin
                rc = (i_a[4*blk+bit_i] & i_b[4*blk+bit_i]) | (w_p[4*blk+bit_i] & rc);
                if (bit_i < 3) c[4*blk+bit_i+1] = rc;
            end
            c[4*blk+4] = (&w_p[4*blk+:4]) ? c[4*blk] : rc;
        end
        o_sum  = w_p ^ c[31:0];
        o_cout = c[32];
    end
endmodule

module wide_add_sequencer #(
    parameter int NWORDS = 4,
    parameter int W      = 32 * NWORDS
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_cin,
    input  logic [W-1:0] i_op_a,
    input  logic [W-1:0] i_op_b,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_sum,
    output logic         o_cout,
    output logic         o_ovf
);
    localparam int IW = $clog2(NWORDS);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [IW-1:0]  r_idx;
    logic           r_carry;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_sum;
    logic           r_cout;
    logic           r_ovf;
    logic           r_done;

    logic           w_accept;
    logic           w_last;
    logic [31:0]    w_word_a;
    logic [31:0]    w_word_b;
    logic [31:0]    w_add_sum;
    logic           w_add_cout;
    logic           w_last_ovf;

    assign w_word_a = r_a[32*r_idx +: 32];
    assign w_word_b = r_b[32*r_idx +: 32];

    CarrySkipAdder32 u_adder (
        .i_a    (w_word_a),
        .i_b    (w_word_b),
        .i_cin  (r_carry),
        .o_sum  (w_add_sum),
        .o_cout (w_add_cout)
    );

    // signed overflow: operands agree in sign but the top result bit does not
    assign w_last_ovf = (r_a[W-1] == r_b[W-1]) && (w_add_sum[31] != r_a[W-1]);

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_idx == IW'(NWORDS - 1)) begin
                    w_last       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            if (w_accept) begin
                r_a     <= i_op_a;
                r_b     <= i_op_b;
                r_carry <= i_cin;
                r_idx   <= '0;
            end else if (r_state == S_RUN) begin
                r_sum[32*r_idx +: 32] <= w_add_sum;
                r_carry               <= w_add_cout;
                if (w_last) begin
                    r_cout <= w_add_cout;
                    r_ovf  <= w_last_ovf;
                    r_done <= 1'b1;
                    r_idx  <= '0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign o_busy = (r_state == S_RUN);
    assign o_done = r_done;
    assign o_sum  = r_sum;
    assign o_cout = r_cout;
    assign o_ovf  = r_ovf;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb/tb_wide_add_sequencer.sv - self-checking bench for wide_add_sequencer
// Reference model works on whole W+1-bit sums; directed literals pin it.

module tb_wide_add_sequencer;
    localparam int NWORDS = 4;
    localparam int W      = 32 * NWORDS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    wide_add_sequencer #(.NWORDS(NWORDS)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_cin   (cin),
        .i_op_a  (op_a),
        .i_op_b  (op_b),
        .o_busy  (busy),
        .o_done  (done),
        .o_sum   (sum),
        .o_cout  (cout),
        .o_ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    // Reference: full-width sum computed at acceptance, revealed one word per busy cycle
    logic [W:0]   m_exp  = '0;
    logic         m_eovf = 1'b0;
    int           m_cnt  = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_sum  = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf  = 1'b0;

    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt == 0) begin
                if (start) begin
                    m_exp  <= {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, cin};
                    m_eovf <= ref_ovf(op_a, op_b, cin);
                    m_cnt  <= NWORDS;
                end
            end else begin
                m_sum[32*(NWORDS-m_cnt) +: 32] <= m_exp[32*(NWORDS-m_cnt) +: 32];
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_done <= 1'b1;
                    m_cout <= m_exp[W];
                    m_ovf  <= m_eovf;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_busy", {{W{1'b0}}, busy}, {{W{1'b0}}, (m_cnt != 0)});
            chk("cyc_done", {{W{1'b0}}, done}, {{W{1'b0}}, m_done});
            chk("cyc_sum",  {1'b0, sum},        {1'b0, m_sum});
            chk("cyc_cout", {{W{1'b0}}, cout}, {{W{1'b0}}, m_cout});
            chk("cyc_ovf",  {{W{1'b0}}, ovf},  {{W{1'b0}}, m_ovf});
        end
    end

    // Drive a start at a negedge; returns edges from acceptance to done and busy cycles seen
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          output int lat, output int nbusy);
        int cyc;
        op_a  = a;
        op_b  = b;
        cin   = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op_a  = {W{1'b1}} ^ a;
        op_b  = {W{1'b1}} ^ b;
        cin   = ~c;
        cyc   = 1;
        nbusy = 0;
        while (!done && cyc < 50) begin
            if (busy) nbusy++;
            @(negedge clk);
            cyc++;
        end
        if (!done) chk("done_timeout", 0, 1);
        lat = cyc - 1;
    endtask

    task automatic wait_done(input string name);
        int cyc;
        cyc = 0;
        while (!done && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) chk(name, 0, 1);
    endtask

    initial begin
        int lat, nb;
        logic [W-1:0] ra, rb;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_sum",  {1'b0, sum}, '0);
        chk("rst_busy", {{W{1'b0}}, busy}, '0);
        chk("rst_done", {{W{1'b0}}, done}, '0);
        rst = 1'b0;
        @(negedge clk);

        // T1
        run_op({W{1'b1}}, 1, 1'b0, lat, nb);
        chk("t1_sum",  {1'b0, sum}, '0);
        chk("t1_cout", {{W{1'b0}}, cout}, 1);
        chk("t1_ovf",  {{W{1'b0}}, ovf}, 0);
        chk("t1_lat",  lat, 4);
        chk("t1_busy_cycles", nb, 4);
        @(negedge clk);

        // T2
        run_op({1'b0, {(W-1){1'b1}}}, 1, 1'b0, lat, nb);
        chk("t2_sum",  {1'b0, sum}, {1'b0, 1'b1, {(W-1){1'b0}}});
        chk("t2_cout", {{W{1'b0}}, cout}, 0);
        chk("t2_ovf",  {{W{1'b0}}, ovf}, 1);

        // T3 started in T2's done cycle
        run_op(128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 0, 1'b1, lat, nb);
        chk("t3_sum",  {1'b0, sum}, {1'b0, 128'h0000_0000_0000_0001_0000_0000_0000_0000});
        chk("t3_cout", {{W{1'b0}}, cout}, 0);
        chk("t3_lat",  lat, 4);
        @(negedge clk);

        // T4: second start mid-run ignored, then start in done cycle accepted
        op_a = 128'd100; op_b = 128'd23; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        op_a = 128'd9999; op_b = 128'd1; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t4a_timeout");
        chk("t4a_sum", {1'b0, sum}, 129'd123);
        run_op(128'd40, 128'd2, 1'b1, lat, nb);
        chk("t4b_sum", {1'b0, sum}, 129'd43);
        chk("t4b_lat", lat, 4);
        @(negedge clk);

        // T5: reset during second RUN cycle
        op_a = {W{1'b1}}; op_b = {W{1'b1}}; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_sum",  {1'b0, sum}, '0);
        chk("t5_rst_busy", {{W{1'b0}}, busy}, 0);
        chk("t5_rst_cout", {{W{1'b0}}, cout}, 0);
        rst = 1'b0;
        nb = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) nb++;
        end
        chk("t5_no_done", nb, 0);
        run_op(128'd5, 128'd7, 1'b0, lat, nb);
        chk("t5_sum", {1'b0, sum}, 129'd12);

        // T6: random, mixed idle gaps and back-to-back starts
        for (int i = 0; i < 1000; i++) begin
            for (int j = 0; j < NWORDS; j++) begin
                ra[32*j +: 32] = $urandom;
                rb[32*j +: 32] = $urandom;
            end
            run_op(ra, rb, 1'($urandom_range(0, 1)), lat, nb);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
